hazard_fwd_unit: RTL and testbench

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

---
 rtl/mips_pkg.sv | 26 ++
 rtl/fwd_mux.sv | 23 ++
 rtl/hazard_fwd_unit.sv | 125 ++++++++++++
 tb/tb_hazard_fwd_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline definitions: stage indices, scoreboard entry layout and default widths.
package mips_pkg;

  localparam int unsigned STG_EXE = 0;
  localparam int unsigned STG_MEM = 1;
  localparam int unsigned STG_WB  = 2;

  localparam int unsigned DEF_REG_W  = 4;
  localparam int unsigned DEF_DATA_W = 32;

  // Destination field is sized for the widest supported register file; narrower
  // register addresses are zero-extended on entry.
  localparam int unsigned SB_DEST_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [SB_DEST_W-1:0] dest;
    logic                 wb_en;
    logic                 mem_read;
  } sb_entry_t;

  function automatic logic sb_match(sb_entry_t e, logic [SB_DEST_W-1:0] src);
    return e.valid && e.wb_en && (e.dest == src);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Priority forwarding select: returns the value of the lowest-index (youngest) matching stage.
module fwd_mux #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned DATA_W     = 32
) (
  input  logic [NUM_STAGES-1:0]        match_i,
  input  logic [NUM_STAGES*DATA_W-1:0] data_i,
  output logic                         hit_o,
  output logic [DATA_W-1:0]            val_o
);

  always_comb begin
    hit_o = |match_i;
    val_o = '0;
    // Walk oldest to youngest so the youngest match is the last assignment.
    for (int k = int'(NUM_STAGES) - 1; k >= 0; k--) begin
      if (match_i[k]) begin
        val_o = data_i[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Scoreboard-based hazard detection and operand forwarding for the ID stage.
import mips_pkg::*;

module hazard_fwd_unit #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned REG_W      = DEF_REG_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter bit          FWD_EN     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [REG_W-1:0]             id_dest,
  input  logic                         id_wb_en,
  input  logic                         id_mem_read,
  input  logic [REG_W-1:0]             src1,
  input  logic [REG_W-1:0]             src2,
  input  logic                         two_src,
  input  logic                         branch_taken,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_data,
  output logic                         stall,
  output logic                         flush,
  output logic                         fwd_hit1,
  output logic                         fwd_hit2,
  output logic [DATA_W-1:0]            fwd_val1,
  output logic [DATA_W-1:0]            fwd_val2,
  output logic [31:0]                  stall_cnt
);

  sb_entry_t sb_q [NUM_STAGES];
  sb_entry_t sb_d [NUM_STAGES];

  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic [SB_DEST_W-1:0]  src1_ext, src2_ext;
  logic [NUM_STAGES-1:0] match1, match2;
  logic [NUM_STAGES-1:0] fwd_match1, fwd_match2;
  logic                  load_use, hazard, fwd_ok;

  assign src1_ext = SB_DEST_W'(src1);
  assign src2_ext = SB_DEST_W'(src2);

  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int k = 0; k < int'(NUM_STAGES); k++) begin
      match1[k] = id_valid && sb_match(sb_q[k], src1_ext);
      match2[k] = id_valid && two_src && sb_match(sb_q[k], src2_ext);
    end
  end

  always_comb begin
    load_use = (match1[STG_EXE] || match2[STG_EXE]) && sb_q[STG_EXE].mem_read;
    if (FWD_EN) begin
      hazard = load_use;
    end else begin
      hazard = (|match1) || (|match2);
    end
    // A taken branch discards ID, so there is nothing left to stall for.
    flush  = branch_taken;
    stall  = hazard && !branch_taken;
    fwd_ok = FWD_EN && !stall;
    fwd_match1 = match1 & {NUM_STAGES{fwd_ok}};
    fwd_match2 = match2 & {NUM_STAGES{fwd_ok}};
  end

  fwd_mux #(
    .NUM_STAGES (NUM_STAGES),
    .DATA_W     (DATA_W)
  ) u_fwd_mux1 (
    .match_i (fwd_match1),
    .data_i  (stage_data),
    .hit_o   (fwd_hit1),
    .val_o   (fwd_val1)
  );

  fwd_mux #(
    .NUM_STAGES (NUM_STAGES),
    .DATA_W     (DATA_W)
  ) u_fwd_mux2 (
    .match_i (fwd_match2),
    .data_i  (stage_data),
    .hit_o   (fwd_hit2),
    .val_o   (fwd_val2)
  );

  always_comb begin
    sb_d = sb_q;
    for (int k = 1; k < int'(NUM_STAGES); k++) begin
      sb_d[k] = sb_q[k-1];
    end
    if (id_valid && !stall && !flush) begin
      sb_d[STG_EXE].valid    = 1'b1;
      sb_d[STG_EXE].dest     = SB_DEST_W'(id_dest);
      sb_d[STG_EXE].wb_en    = id_wb_en;
      sb_d[STG_EXE].mem_read = id_mem_read;
    end else begin
      sb_d[STG_EXE] = '0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(NUM_STAGES); k++) begin
        sb_q[k] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_STAGES); k++) begin
        sb_q[k] <= sb_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench: a forwarding instance driven from a vector table plus hand sequences,
// and a stall-only instance sharing the same inputs.
module tb_hazard_fwd_unit;

  localparam int unsigned NS = 3;
  localparam int unsigned RW = 4;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_wb_en, id_mem_read, two_src, branch_taken;
  logic [RW-1:0] id_dest, src1, src2;
  logic [NS*DW-1:0] stage_data;

  logic          a_stall, a_flush, a_hit1, a_hit2;
  logic [DW-1:0] a_val1, a_val2;
  logic [31:0]   a_cnt;
  logic          b_stall, b_flush, b_hit1, b_hit2;
  logic [DW-1:0] b_val1, b_val2;
  logic [31:0]   b_cnt;

  logic [DW-1:0] sd [NS];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.NUM_STAGES(NS), .REG_W(RW), .DATA_W(DW), .FWD_EN(1'b1)) dut_a (
    .clk (clk), .rst (rst), .id_valid (id_valid), .id_dest (id_dest),
    .id_wb_en (id_wb_en), .id_mem_read (id_mem_read), .src1 (src1), .src2 (src2),
    .two_src (two_src), .branch_taken (branch_taken), .stage_data (stage_data),
    .stall (a_stall), .flush (a_flush), .fwd_hit1 (a_hit1), .fwd_hit2 (a_hit2),
    .fwd_val1 (a_val1), .fwd_val2 (a_val2), .stall_cnt (a_cnt)
  );

  hazard_fwd_unit #(.NUM_STAGES(NS), .REG_W(RW), .DATA_W(DW), .FWD_EN(1'b0)) dut_b (
    .clk (clk), .rst (rst), .id_valid (id_valid), .id_dest (id_dest),
    .id_wb_en (id_wb_en), .id_mem_read (id_mem_read), .src1 (src1), .src2 (src2),
    .two_src (two_src), .branch_taken (branch_taken), .stage_data (stage_data),
    .stall (b_stall), .flush (b_flush), .fwd_hit1 (b_hit1), .fwd_hit2 (b_hit2),
    .fwd_val1 (b_val1), .fwd_val2 (b_val2), .stall_cnt (b_cnt)
  );

  typedef struct {
    logic          id_valid;
    logic [RW-1:0] id_dest;
    logic          wb_en;
    logic          mem_read;
    logic [RW-1:0] s1;
    logic [RW-1:0] s2;
    logic          two;
    logic          br;
    logic          e_stall;
    logic          e_flush;
    logic          e_hit1;
    int            e_sel1;
    logic          e_hit2;
    int            e_sel2;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] sel_val(input int sel);
    return (sel < 0) ? '0 : sd[sel];
  endfunction

  task automatic set_id(input logic v, input logic [RW-1:0] d, input logic wb, input logic mr,
                        input logic [RW-1:0] s1, input logic [RW-1:0] s2, input logic two,
                        input logic br);
    id_valid = v; id_dest = d; id_wb_en = wb; id_mem_read = mr;
    src1 = s1; src2 = s2; two_src = two; branch_taken = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_id(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    sd[0] = 32'h1000_0001;
    sd[1] = 32'h2000_0002;
    sd[2] = 32'h3000_0003;
    stage_data = {sd[2], sd[1], sd[0]};
    rst = 1'b0;

    //             v  dst wb mr s1 s2 two br | stl fl h1 sel1 h2 sel2
    vecs[0] = '{1'b0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, -1, 0, -1};
    vecs[1] = '{1'b1, 3, 1, 0, 3, 3, 1, 0, 0, 0, 0, -1, 0, -1};
    vecs[2] = '{1'b1, 6, 1, 0, 3, 0, 0, 0, 0, 0, 1,  0, 0, -1};
    vecs[3] = '{1'b1, 4, 1, 0, 1, 2, 1, 0, 0, 0, 0, -1, 0, -1};
    vecs[4] = '{1'b1, 9, 1, 0, 3, 4, 0, 0, 0, 0, 1,  2, 0, -1};
    vecs[5] = '{1'b1, 4, 1, 0, 0, 6, 1, 0, 0, 0, 0, -1, 1,  2};
    vecs[6] = '{1'b1, 1, 0, 0, 4, 9, 1, 0, 0, 0, 1,  0, 1,  1};
    vecs[7] = '{1'b0, 0, 0, 0, 4, 9, 1, 0, 0, 0, 0, -1, 0, -1};
    vecs[8] = '{1'b1, 1, 0, 0, 1, 4, 1, 0, 0, 0, 0, -1, 1,  2};
    vecs[9] = '{1'b0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, -1, 0, -1};

    do_reset();
    chk("reset_cnt_a", a_cnt, 32'd0);
    chk("reset_cnt_b", b_cnt, 32'd0);

    foreach (vecs[i]) begin
      set_id(vecs[i].id_valid, vecs[i].id_dest, vecs[i].wb_en, vecs[i].mem_read,
             vecs[i].s1, vecs[i].s2, vecs[i].two, vecs[i].br);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(a_stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_flush", i), 32'(a_flush), 32'(vecs[i].e_flush));
      chk($sformatf("v%0d_hit1", i), 32'(a_hit1), 32'(vecs[i].e_hit1));
      chk($sformatf("v%0d_val1", i), a_val1, sel_val(vecs[i].e_sel1));
      chk($sformatf("v%0d_hit2", i), 32'(a_hit2), 32'(vecs[i].e_hit2));
      chk($sformatf("v%0d_val2", i), a_val2, sel_val(vecs[i].e_sel2));
      tick();
    end

    // Load-use: one stall cycle, then forward from MEM.
    do_reset();
    set_id(1'b1, 5, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 7, 1'b1, 1'b0, 0, 5, 1'b1, 1'b0);
    #1;
    chk("lu_stall", 32'(a_stall), 32'd1);
    chk("lu_hit2_during_stall", 32'(a_hit2), 32'd0);
    tick();
    chk("lu_stall_after", 32'(a_stall), 32'd0);
    chk("lu_hit2", 32'(a_hit2), 32'd1);
    chk("lu_val2", a_val2, sd[1]);
    chk("lu_cnt", a_cnt, 32'd1);
    set_id(1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    chk("lu_cnt_hold", a_cnt, 32'd1);

    // No forwarding: dependent instruction stalls until the producer leaves WB.
    do_reset();
    set_id(1'b1, 2, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 8, 1'b1, 1'b0, 2, 0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("nofwd_stall_c%0d", c), 32'(b_stall), 32'd1);
      chk($sformatf("nofwd_hit1_c%0d", c), 32'(b_hit1), 32'd0);
      tick();
    end
    chk("nofwd_stall_end", 32'(b_stall), 32'd0);
    chk("nofwd_val1_end", b_val1, 32'd0);
    chk("nofwd_cnt", b_cnt, 32'd3);

    // Load-use coinciding with a taken branch: flush wins, ID is not captured.
    do_reset();
    set_id(1'b1, 5, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 7, 1'b1, 1'b0, 5, 0, 1'b0, 1'b1);
    #1;
    chk("br_flush", 32'(a_flush), 32'd1);
    chk("br_stall", 32'(a_stall), 32'd0);
    tick();
    set_id(1'b1, 0, 1'b0, 1'b0, 7, 5, 1'b1, 1'b0);
    #1;
    chk("br_entry0_empty", 32'(a_hit1), 32'd0);
    chk("br_load_in_mem", a_val2, sd[1]);
    chk("br_cnt", a_cnt, 32'd0);

    // Reset in the middle of a stall.
    do_reset();
    set_id(1'b1, 5, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 7, 1'b1, 1'b0, 5, 0, 1'b0, 1'b0);
    #1;
    chk("rs_stall_pre", 32'(a_stall), 32'd1);
    tick();
    chk("rs_cnt_pre", a_cnt, 32'd1);
    // Make the load stall again, then reset over it.
    set_id(1'b1, 5, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 7, 1'b1, 1'b0, 5, 0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rs_stall_post", 32'(a_stall), 32'd0);
    chk("rs_hit1_post", 32'(a_hit1), 32'd0);
    chk("rs_cnt_post", a_cnt, 32'd0);

    // Saturation: preload the counter, then take one more stall.
    set_id(1'b1, 5, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 7, 1'b1, 1'b0, 5, 0, 1'b0, 1'b0);
    force dut_a.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut_a.stall_cnt_q;
    #1;
    chk("sat_stall", 32'(a_stall), 32'd1);
    chk("sat_preload", a_cnt, 32'hFFFF_FFFF);
    tick();
    chk("sat_cnt", a_cnt, 32'hFFFF_FFFF);
    chk("sat_stall_done", 32'(a_stall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
